// File: rtl/int_seq_ctrl.sv
// Interrupt / halt sequencer: drains the pipeline, pushes the resume PC, fetches the ISR vector and loads it.
// Optional CCR shadow save/restore is built when INT_FLAG_SAVE_EN is defined.
module int_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] VECTOR_ADDR = 'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req,
  input  logic              hlt_en,
  input  logic              rti_wb,
  input  logic              pipe_empty,
  input  logic [ADDR_W-1:0] resume_pc,
  input  logic [DATA_W-1:0] sp_val,
  input  logic [3:0]        flags_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_stall,
  output logic              pipe_flush,
  output logic              mem_sel,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              sp_dec,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              in_isr,
  output logic              halted,
  output logic              flags_restore,
  output logic [3:0]        flags_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_HALT, S_PUSH_PC, S_RD_VEC, S_LD_PC
  } state_t;

  state_t            state, next_state;
  logic              int_req_d;
  logic              int_pend;
  logic [ADDR_W-1:0] pc_save;
  logic              capture_pc;
  logic              enter_halt;
  logic              enter_push;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      int_req_d  <= 1'b0;
      int_pend   <= 1'b0;
      in_isr     <= 1'b0;
      pc_save    <= '0;
      pipe_flush <= 1'b0;
    end else begin
      state     <= next_state;
      int_req_d <= int_req;
      // A fresh edge wins over the clear so it is never lost; edges while pending merge.
      if (int_req && !int_req_d) int_pend <= 1'b1;
      else if (enter_push)       int_pend <= 1'b0;
      if (state == S_LD_PC) in_isr <= 1'b1;
      else if (rti_wb)      in_isr <= 1'b0;
      if (capture_pc) pc_save <= resume_pc;
      pipe_flush <= enter_halt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state  = state;
    capture_pc  = 1'b0;
    enter_halt  = 1'b0;
    enter_push  = 1'b0;
    fetch_stall = 1'b0;
    halted      = 1'b0;
    mem_sel     = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sp_dec      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    case (state)
      S_IDLE: begin
        if (hlt_en) begin
          next_state = S_HALT;
          enter_halt = 1'b1;
          capture_pc = 1'b1;
        end else if (int_pend && !in_isr) begin
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        fetch_stall = 1'b1;
        if (hlt_en) begin
          next_state = S_HALT;
          enter_halt = 1'b1;
          capture_pc = 1'b1;
        end else if (pipe_empty) begin
          next_state = S_PUSH_PC;
          capture_pc = 1'b1;
          enter_push = 1'b1;
        end
      end
      S_HALT: begin
        fetch_stall = 1'b1;
        halted      = 1'b1;
        if (int_pend) begin
          next_state = S_PUSH_PC;
          enter_push = 1'b1;
        end
      end
      S_PUSH_PC: begin
        fetch_stall = 1'b1;
        mem_sel     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = sp_val[ADDR_W-1:0];
        mem_wdata   = DATA_W'(pc_save);
        sp_dec      = 1'b1;
        next_state  = S_RD_VEC;
      end
      S_RD_VEC: begin
        fetch_stall = 1'b1;
        mem_sel     = 1'b1;
        mem_re      = 1'b1;
        mem_addr    = VECTOR_ADDR;
        next_state  = S_LD_PC;
      end
      S_LD_PC: begin
        fetch_stall = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = mem_rdata[ADDR_W-1:0];
        next_state  = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

`ifdef INT_FLAG_SAVE_EN
  logic [3:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow        <= '0;
      flags_restore <= 1'b0;
      flags_out     <= '0;
    end else begin
      if (state == S_PUSH_PC) shadow <= flags_in;
      flags_restore <= rti_wb && in_isr;
      flags_out     <= (rti_wb && in_isr) ? shadow : 4'b0;
    end
  end
`else
  logic unused_flags;
  assign unused_flags  = ^flags_in;
  assign flags_restore = 1'b0;
  assign flags_out     = 4'b0;
`endif

endmodule

// File: doc/int_seq_ctrl.md
Name: int_seq_ctrl

Overview:
- Multi-cycle interrupt and halt sequencer for the pipelined processor.
- On an interrupt it:
  - stops fetch and drains the pipeline,
  - takes the data-memory port from the pipeline,
  - pushes the resume PC at R3 (SP) and decrements SP,
  - reads the ISR address from a fixed vector location and loads it into the PC.
- Also owns the HALT state requested by the WB stage's HLT_en; only an interrupt exits HALT.

Parameters:
- ADDR_W, 8, PC and data-memory address width.
- DATA_W, 8, data-memory word width (ADDR_W <= DATA_W).
- VECTOR_ADDR, 8'h01, memory address holding the ISR start address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- int_req  in  1  external interrupt line, synchronous to clk; rising edge requests.
- hlt_en  in  1  HLT instruction retiring in WB (from WB control).
- rti_wb  in  1  RTI retiring in WB.
- pipe_empty  in  1  no valid instruction in decode/execute/mem/WB.
- resume_pc  in  ADDR_W  address of next instruction to fetch.
- sp_val  in  DATA_W  current R3 value.
- flags_in  in  4  current CCR {V,C,N,Z}.
- mem_rdata  in  DATA_W  data-memory read data; synchronous read, 1-cycle latency.
- fetch_stall  out  1  freeze PC and fetch.
- pipe_flush  out  1  single-cycle pulse: squash decode/execute/mem.
- mem_sel  out  1  1 = this block drives the data-memory port.
- mem_we, mem_re  out  1  memory write / read strobes.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- sp_dec  out  1  decrement R3 this cycle.
- pc_load  out  1  load pc_load_val into PC.
- pc_load_val  out  ADDR_W  new PC.
- in_isr  out  1  ISR active; nesting blocked.
- halted  out  1  processor in HALT.
- flags_restore  out  1  load CCR from flags_out (feature only).
- flags_out  out  4  saved CCR (feature only).

Behaviour:
- Reset:
  - State IDLE; all outputs 0; int_pend, in_isr, pc_save and shadow flags cleared.
  - Reset asserted mid-sequence aborts it immediately, with no partial push/load completion.
- Interrupt capture:
  - int_pend is set on the cycle after int_req goes 0->1.
  - Cleared on entry to PUSH_PC; further edges while set are merged.
  - While in_isr=1, int_pend is held and taken after RTI.
- IDLE:
  - If hlt_en=1: go to HALT, pulse pipe_flush, capture pc_save<=resume_pc. HLT has priority over a same-cycle int_pend.
  - Else if int_pend=1 and in_isr=0: go to DRAIN.
- DRAIN:
  - fetch_stall=1.
  - When pipe_empty=1: capture pc_save<=resume_pc and go to PUSH_PC.
  - hlt_en seen while in DRAIN: go to HALT (pulse flush, capture pc_save); int_pend remains set.
- HALT:
  - fetch_stall=1, halted=1.
  - When int_pend=1: go to PUSH_PC. halted drops in PUSH_PC.
- PUSH_PC (1 cycle):
  - mem_sel=1, mem_we=1, mem_addr=sp_val[ADDR_W-1:0], mem_wdata=zero-extended pc_save, sp_dec=1, fetch_stall=1.
- RD_VEC (1 cycle): mem_sel=1, mem_re=1, mem_addr=VECTOR_ADDR, fetch_stall=1.
- LD_PC (1 cycle):
  - pc_load=1, pc_load_val=mem_rdata[ADDR_W-1:0], fetch_stall=1.
  - in_isr<=1; next state IDLE.
- Interrupt latency: from pipe_empty in DRAIN to pc_load, exactly 3 cycles (PUSH_PC, RD_VEC, LD_PC).
- SP wrap: sp_val 0x00 is written at address 0x00; the wrap to 0xFF is the register file's job, with no special case here.
- RTI: rti_wb=1 clears in_isr the next cycle. rti_wb while in_isr=0 is ignored.
- Outputs are decoded from the registered state and are glitch-free; mem_sel is 0 in every state except PUSH_PC and RD_VEC.

Optional Feature:
- Macro: INT_FLAG_SAVE_EN.
- Defined:
  - In PUSH_PC, shadow<=flags_in.
  - On rti_wb with in_isr=1: flags_restore=1 for 1 cycle and flags_out=shadow.
- Undefined: flags_restore and flags_out are tied to 0 and no shadow register is built; the ISR must save flags in software.

Test Plan:
- Basic interrupt:
  - Stimulus: IDLE, sp_val=0xFF, resume_pc=0x20 at drain, mem[0x01]=0x80; int_req rises; pipe_empty=1 after 3 cycles.
  - Response: write 0x20 to 0xFF with sp_dec; read 0x01; pc_load with 0x80; in_isr=1; pipe_empty->pc_load = 3 cycles.
- Halt then wake:
  - Stimulus: hlt_en with resume_pc=0x11.
  - Response: pipe_flush pulses and halted=1 for 50 idle cycles; an int_req edge gives push 0x11, then pc_load from the vector.
- Blocked nesting:
  - Stimulus: second int_req edge while in_isr=1.
  - Response: no DRAIN; after rti_wb, in_isr=0 and the pending interrupt sequence starts.
- Simultaneous events:
  - Stimulus: hlt_en and int_pend high in the same IDLE cycle.
  - Response: HALT entered, then exited next cycle into PUSH_PC.
- Reset mid-sequence:
  - Stimulus: rst asserted during RD_VEC.
  - Response: mem_sel, mem_re and pc_load go 0 immediately; state IDLE; int_pend=0.
- INT_FLAG_SAVE_EN:
  - Stimulus: flags_in=4'b1010 at PUSH_PC, then flags_in changed, then rti_wb.
  - Response: flags_restore pulses once with flags_out=4'b1010. With the macro undefined, both outputs stay 0.
